mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/lc3b_types.sv | 5 +
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared word type and arbiter state encoding.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} lc3b_arb_state;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access.
module mem_port_arbiter
    import lc3b_types::*;
(
    input  logic           clk,
    input  logic           reset,
    input  lc3b_word       i_addr,
    input  logic           i_read,
    output lc3b_word       i_rdata,
    output logic           i_resp,
    input  lc3b_word       d_addr,
    input  logic           d_read,
    input  logic           d_write,
    input  lc3b_word       d_wdata,
    input  logic [1:0]     d_byte_enable,
    output lc3b_word       d_rdata,
    output logic           d_resp,
    output lc3b_word       m_addr,
    output lc3b_word       m_wdata,
    output logic           m_read,
    output logic           m_write,
    output logic [1:0]     m_byte_enable,
    input  lc3b_word       m_rdata,
    input  logic           m_resp
);
    lc3b_arb_state state, state_next;
    lc3b_word addr_q, wdata_q;
    logic [1:0] be_q;
    logic wr_q, last_d, grant_i, grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            last_d  <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                be_q    <= d_byte_enable;
                wr_q    <= d_write;
                last_d  <= 1'b1;
            end else if (grant_i) begin
                addr_q <= i_addr;
                be_q   <= 2'b11;
                wr_q   <= 1'b0;
                last_d <= 1'b0;
            end
        end
    end

    // d_write dominates d_read, so a simultaneous read+write is issued as a write
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        m_read     = 1'b0;
        m_write    = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            IDLE: begin
                grant_d    = (d_read || d_write) && (!i_read || !last_d);
                grant_i    = i_read && !grant_d;
                state_next = grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE;
            end
            SERVE_I: begin
                m_read     = 1'b1;
                i_resp     = m_resp;
                state_next = m_resp ? RECOVER : SERVE_I;
            end
            SERVE_D: begin
                m_read     = !wr_q;
                m_write    = wr_q;
                d_resp     = m_resp;
                state_next = m_resp ? RECOVER : SERVE_D;
            end
            default: state_next = IDLE;
        endcase
        // reset squashes strobes immediately, even mid-transaction
        if (reset) begin
            m_read  = 1'b0;
            m_write = 1'b0;
            i_resp  = 1'b0;
            d_resp  = 1'b0;
        end
    end

    assign i_rdata       = m_rdata;
    assign d_rdata       = m_rdata;
    assign m_addr        = addr_q;
    assign m_wdata       = wdata_q;
    assign m_byte_enable = be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a transaction-level arbiter model.
module tb_mem_port_arbiter;
    import lc3b_types::*;

    localparam int NONE = 0, PI = 1, PD = 2;

    logic clk = 1'b0;
    logic reset, i_read, d_read, d_write, m_resp;
    lc3b_word i_addr, d_addr, d_wdata, m_rdata;
    logic [1:0] d_byte_enable;
    lc3b_word i_rdata, d_rdata, m_addr, m_wdata;
    logic i_resp, d_resp, m_read, m_write;
    logic [1:0] m_byte_enable;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
        .m_byte_enable(m_byte_enable), .m_rdata(m_rdata), .m_resp(m_resp)
    );

    int tests = 0, fails = 0, cyc = 0;
    int owner = NONE, lat = 0, wcnt = 0, fi = 0, fd = 0;
    bit cool = 0, last_d = 0, e_wr = 0;
    lc3b_word e_addr = 0, e_wdata = 0;
    logic [1:0] e_be = 0;
    bit saw_i = 0, saw_d = 0, hold_i = 0, hold_d = 0;
    int glog[$], gcyc[$], dlog[$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // compare the DUT against what the model says this cycle should look like
    task automatic settle();
        @(negedge clk);
        if (reset) begin
            chk("rst_m_read", 32'(m_read), 0);
            chk("rst_m_write", 32'(m_write), 0);
            chk("rst_i_resp", 32'(i_resp), 0);
            chk("rst_d_resp", 32'(d_resp), 0);
        end else begin
            chk("m_read", 32'(m_read), 32'(owner == PI || (owner == PD && !e_wr)));
            chk("m_write", 32'(m_write), 32'(owner == PD && e_wr));
            chk("i_resp", 32'(i_resp), 32'(owner == PI && m_resp));
            chk("d_resp", 32'(d_resp), 32'(owner == PD && m_resp));
            chk("i_rdata", 32'(i_rdata), 32'(m_rdata));
            chk("d_rdata", 32'(d_rdata), 32'(m_rdata));
            if (owner != NONE) begin
                chk("m_addr", 32'(m_addr), 32'(e_addr));
                chk("m_be", 32'(m_byte_enable), 32'(e_be));
                if (owner == PD && e_wr) chk("m_wdata", 32'(m_wdata), 32'(e_wdata));
            end
        end
        saw_i = i_resp;
        saw_d = d_resp;
    endtask

    // advance the model by one cycle, then step to just after the next edge
    task automatic next_cyc();
        if (reset) begin
            owner = NONE; cool = 0; last_d = 0; e_wr = 0;
            e_addr = 0; e_wdata = 0; e_be = 0; fi = 0; fd = 0;
        end else if (owner != NONE) begin
            if (m_resp) begin
                if (owner == PD && i_read) fi++;
                if (owner == PI && (d_read || d_write)) fd++;
                dlog.push_back(cyc);
                owner = NONE;
                cool = 1;
            end
        end else if (cool) begin
            cool = 0;
        end else if ((d_read || d_write) && (!i_read || !last_d)) begin
            chk("fair_d", 32'(fd <= 1), 1);
            owner = PD; last_d = 1; fd = 0;
            e_addr = d_addr; e_wdata = d_wdata; e_be = d_byte_enable; e_wr = d_write;
            glog.push_back(PD); gcyc.push_back(cyc);
            lat = $urandom % 4; wcnt = 0;
        end else if (i_read) begin
            chk("fair_i", 32'(fi <= 1), 1);
            owner = PI; last_d = 0; fi = 0;
            e_addr = i_addr; e_be = 2'b11; e_wr = 0;
            glog.push_back(PI); gcyc.push_back(cyc);
            lat = $urandom % 4; wcnt = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // requesters (raise with probability 1/den, drop on resp) and a random-latency memory
    task automatic drive(input int den);
        if (saw_i) begin i_read = 0; hold_i = 0; end
        else if (i_read && owner == PI && den > 1 && $urandom % 16 == 0) begin i_read = 0; hold_i = 1; end
        else if (!i_read && !hold_i && den != 0 && $urandom % den == 0) begin
            i_read = 1; i_addr = 16'($urandom);
        end
        if (saw_d) begin d_read = 0; d_write = 0; hold_d = 0; end
        else if ((d_read || d_write) && owner == PD && den > 1 && $urandom % 16 == 0) begin
            d_read = 0; d_write = 0; hold_d = 1;
        end else if (!(d_read || d_write) && !hold_d && den != 0 && $urandom % den == 0) begin
            int r = $urandom % 3;
            d_read = (r != 1); d_write = (r != 0);
            d_addr = 16'($urandom); d_wdata = 16'($urandom); d_byte_enable = 2'($urandom);
        end
        if (owner != NONE) begin m_resp = (wcnt >= lat); wcnt++; end
        else m_resp = ($urandom % 8 == 0);
        m_rdata = 16'($urandom);
    endtask

    task automatic run_until(input int den, input int n, input int limit);
        for (int k = 0; k < limit && dlog.size() < n; k++) begin
            drive(den); settle(); next_cyc();
        end
        chk("run_timeout", 32'(dlog.size() >= n), 1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            drive(0); settle(); next_cyc();
            done = owner == NONE && !cool && !i_read && !d_read && !d_write;
        end
        m_resp = 0;
        chk("drain_timeout", 32'(done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; i_read = 0; d_read = 0; d_write = 0; m_resp = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_byte_enable = 0; m_rdata = 0;
        @(posedge clk); #1;
        settle(); next_cyc();
        reset = 0;
        settle();
        chk("rst_addr", 32'(m_addr), 0);
        chk("rst_be", 32'(m_byte_enable), 0);
        chk("rst_wdata", 32'(m_wdata), 0);
        next_cyc();

        // single fetch, memory answers on the third request cycle
        i_read = 1; i_addr = 16'h3000;
        settle(); next_cyc();
        repeat (2) begin settle(); chk("i_wait_m_read", 32'(m_read), 1); next_cyc(); end
        m_resp = 1; m_rdata = 16'h1234;
        settle();
        chk("i_resp_pulse", 32'(i_resp), 1);
        chk("i_rdata_1234", 32'(i_rdata), 32'h1234);
        chk("i_addr_3000", 32'(m_addr), 32'h3000);
        chk("i_be_11", 32'(m_byte_enable), 32'h3);
        next_cyc();
        i_read = 0; m_resp = 0;
        settle();
        chk("recover_m_read", 32'(m_read), 0);
        chk("recover_i_resp", 32'(i_resp), 0);
        next_cyc();

        // store
        d_write = 1; d_addr = 16'h4002; d_wdata = 16'hBEEF; d_byte_enable = 2'b10;
        settle(); next_cyc();
        settle();
        chk("st_m_write", 32'(m_write), 1);
        chk("st_m_read", 32'(m_read), 0);
        chk("st_addr", 32'(m_addr), 32'h4002);
        chk("st_wdata", 32'(m_wdata), 32'hBEEF);
        chk("st_be", 32'(m_byte_enable), 32'h2);
        next_cyc();
        m_resp = 1;
        settle();
        chk("st_d_resp", 32'(d_resp), 1);
        chk("st_i_resp", 32'(i_resp), 0);
        next_cyc();
        d_write = 0; m_resp = 0;
        settle(); next_cyc();

        // read and write together behaves as write
        d_read = 1; d_write = 1; d_addr = 16'h0042; d_wdata = 16'h5A5A;
        settle(); next_cyc();
        m_resp = 1;
        settle();
        chk("rw_m_write", 32'(m_write), 1);
        chk("rw_m_read", 32'(m_read), 0);
        next_cyc();
        d_read = 0; d_write = 0; m_resp = 0;
        settle(); next_cyc();

        // simultaneous requests straight after reset: D first, I after D's recover cycle
        reset = 1; settle(); next_cyc(); reset = 0;
        glog.delete(); gcyc.delete(); dlog.delete();
        i_read = 1; i_addr = 16'h1111; d_read = 1; d_write = 0; d_addr = 16'h2222;
        run_until(0, 2, 60);
        chk("first_grant_d", 32'(glog[0]), 32'(PD));
        chk("second_grant_i", 32'(glog[1]), 32'(PI));
        chk("i_after_recover", 32'(gcyc[1]), 32'(dlog[0] + 2));

        // sustained contention alternates
        glog.delete(); gcyc.delete(); dlog.delete();
        run_until(1, 4, 200);
        chk("alt0_d", 32'(glog[0]), 32'(PD));
        chk("alt1_i", 32'(glog[1]), 32'(PI));
        chk("alt2_d", 32'(glog[2]), 32'(PD));
        chk("alt3_i", 32'(glog[3]), 32'(PI));
        drain();

        // reset in the middle of a fetch, with a late memory response
        i_read = 1; i_addr = 16'h7000;
        settle(); next_cyc();
        settle();
        chk("pre_rst_m_read", 32'(m_read), 1);
        next_cyc();
        reset = 1; m_resp = 1;
        settle();
        chk("mid_rst_m_read", 32'(m_read), 0);
        chk("mid_rst_i_resp", 32'(i_resp), 0);
        next_cyc();
        reset = 0; i_read = 0;
        settle();
        chk("late_resp_i_resp", 32'(i_resp), 0);
        chk("late_resp_m_read", 32'(m_read), 0);
        next_cyc();
        m_resp = 0;

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            drive(3); settle(); next_cyc();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
